// File: rtl/ex_operand_stage_if.sv
// ID/EX operand-stage bundle: decoded instruction in, forwarding producers in,
// ALU operands and registered EX control out.
interface ex_operand_stage_if #(
  parameter int unsigned W = 32
);
  logic         i_id_valid;
  logic [W-1:0] i_id_pc;
  logic [W-1:0] i_id_rs1_data;
  logic [W-1:0] i_id_rs2_data;
  logic [4:0]   i_id_rs1;
  logic [4:0]   i_id_rs2;
  logic [4:0]   i_id_rd;
  logic [W-1:0] i_id_imm;
  logic [2:0]   i_id_alu_op;
  logic [1:0]   i_id_alu_shift;
  logic         i_id_src_a_pc;
  logic         i_id_src_b_imm;
  logic         i_id_reg_write;
  logic         i_id_mem_read;
  logic         i_id_mem_write;
  logic         i_stall;
  logic         i_flush;
  logic [4:0]   i_exmem_rd;
  logic         i_exmem_reg_write;
  logic [W-1:0] i_exmem_result;
  logic [4:0]   i_memwb_rd;
  logic         i_memwb_reg_write;
  logic [W-1:0] i_memwb_result;

  logic [W-1:0] o_op_a;
  logic [W-1:0] o_op_b;
  logic [2:0]   o_alu_op;
  logic [1:0]   o_alu_shift;
  logic [W-1:0] o_store_data;
  logic [W-1:0] o_ex_pc;
  logic [4:0]   o_ex_rd;
  logic         o_ex_valid;
  logic         o_ex_reg_write;
  logic         o_ex_mem_read;
  logic         o_ex_mem_write;
  logic         o_load_use_hazard;

  modport master (
    output i_id_valid, i_id_pc, i_id_rs1_data, i_id_rs2_data, i_id_rs1, i_id_rs2, i_id_rd,
           i_id_imm, i_id_alu_op, i_id_alu_shift, i_id_src_a_pc, i_id_src_b_imm,
           i_id_reg_write, i_id_mem_read, i_id_mem_write, i_stall, i_flush,
           i_exmem_rd, i_exmem_reg_write, i_exmem_result,
           i_memwb_rd, i_memwb_reg_write, i_memwb_result,
    input  o_op_a, o_op_b, o_alu_op, o_alu_shift, o_store_data, o_ex_pc, o_ex_rd,
           o_ex_valid, o_ex_reg_write, o_ex_mem_read, o_ex_mem_write, o_load_use_hazard
  );

  modport slave (
    input  i_id_valid, i_id_pc, i_id_rs1_data, i_id_rs2_data, i_id_rs1, i_id_rs2, i_id_rd,
           i_id_imm, i_id_alu_op, i_id_alu_shift, i_id_src_a_pc, i_id_src_b_imm,
           i_id_reg_write, i_id_mem_read, i_id_mem_write, i_stall, i_flush,
           i_exmem_rd, i_exmem_reg_write, i_exmem_result,
           i_memwb_rd, i_memwb_reg_write, i_memwb_result,
    output o_op_a, o_op_b, o_alu_op, o_alu_shift, o_store_data, o_ex_pc, o_ex_rd,
           o_ex_valid, o_ex_reg_write, o_ex_mem_read, o_ex_mem_write, o_load_use_hazard
  );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX-stage rs1/rs2 forwarding, operand select and
// load-use hazard detection.
module ex_operand_stage #(
  parameter int unsigned XLEN = 1
) (
  input logic               i_clk,
  input logic               i_rst_n,
  ex_operand_stage_if.slave bus
);
  localparam int unsigned W = 1 << (XLEN + 4);

  typedef struct packed {
    logic         valid;
    logic         reg_write;
    logic         mem_read;
    logic         mem_write;
    logic         src_a_pc;
    logic         src_b_imm;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [4:0]   rd;
    logic [W-1:0] rs1_data;
    logic [W-1:0] rs2_data;
    logic [W-1:0] pc;
    logic [W-1:0] imm;
    logic [2:0]   alu_op;
    logic [1:0]   alu_shift;
  } ex_entry_t;

  ex_entry_t    ex_q, ex_d, id_entry;
  logic [W-1:0] fwd_rs1, fwd_rs2;
  logic         load_use;

  function automatic logic [W-1:0] fwd(input logic [4:0] rs, input logic [W-1:0] reg_data);
    logic [W-1:0] val;
    val = reg_data;
    if (bus.i_exmem_reg_write && bus.i_exmem_rd != 5'd0 && bus.i_exmem_rd == rs) begin
      val = bus.i_exmem_result;
    end else if (bus.i_memwb_reg_write && bus.i_memwb_rd != 5'd0 && bus.i_memwb_rd == rs) begin
      val = bus.i_memwb_result;
    end
    return val;
  endfunction

  always_comb begin
    fwd_rs1 = fwd(ex_q.rs1, ex_q.rs1_data);
    fwd_rs2 = fwd(ex_q.rs2, ex_q.rs2_data);
  end

  // Conservative: compares both rs fields without knowing whether ID uses them.
  assign load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) && bus.i_id_valid &&
                    ((ex_q.rd == bus.i_id_rs1) || (ex_q.rd == bus.i_id_rs2));

  always_comb begin
    id_entry           = '0;
    id_entry.valid     = 1'b1;
    id_entry.reg_write = bus.i_id_reg_write;
    id_entry.mem_read  = bus.i_id_mem_read;
    id_entry.mem_write = bus.i_id_mem_write;
    id_entry.src_a_pc  = bus.i_id_src_a_pc;
    id_entry.src_b_imm = bus.i_id_src_b_imm;
    id_entry.rs1       = bus.i_id_rs1;
    id_entry.rs2       = bus.i_id_rs2;
    id_entry.rd        = bus.i_id_rd;
    id_entry.rs1_data  = bus.i_id_rs1_data;
    id_entry.rs2_data  = bus.i_id_rs2_data;
    id_entry.pc        = bus.i_id_pc;
    id_entry.imm       = bus.i_id_imm;
    id_entry.alu_op    = bus.i_id_alu_op;
    id_entry.alu_shift = bus.i_id_alu_shift;
  end

  always_comb begin
    ex_d = ex_q;
    if (bus.i_flush) begin
      ex_d = '0;
    end else if (bus.i_stall) begin
      // Refresh so a producer retiring during the stall is not lost.
      ex_d.rs1_data = fwd_rs1;
      ex_d.rs2_data = fwd_rs2;
    end else if (load_use || !bus.i_id_valid) begin
      ex_d = '0;
    end else begin
      ex_d = id_entry;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign bus.o_op_a            = ex_q.src_a_pc ? ex_q.pc : fwd_rs1;
  assign bus.o_op_b            = ex_q.src_b_imm ? ex_q.imm : fwd_rs2;
  assign bus.o_store_data      = fwd_rs2;
  assign bus.o_alu_op          = ex_q.alu_op;
  assign bus.o_alu_shift       = ex_q.alu_shift;
  assign bus.o_ex_pc           = ex_q.pc;
  assign bus.o_ex_rd           = ex_q.rd;
  assign bus.o_ex_valid        = ex_q.valid;
  assign bus.o_ex_reg_write    = ex_q.reg_write;
  assign bus.o_ex_mem_read     = ex_q.mem_read;
  assign bus.o_ex_mem_write    = ex_q.mem_write;
  assign bus.o_load_use_hazard = load_use;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Randomized and directed bench for ex_operand_stage against an instruction-level
// model of the EX slot.
module tb_ex_operand_stage;
  localparam int unsigned XLEN = 1;
  localparam int unsigned W    = 32;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  ex_operand_stage_if #(.W(W)) bus ();

  ex_operand_stage #(.XLEN(XLEN)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The instruction currently sitting in EX, as the model sees it.
  typedef struct packed {
    logic         valid, rw, mr, mw, a_pc, b_imm;
    logic [4:0]   rs1, rs2, rd;
    logic [W-1:0] d1, d2, pc, imm;
    logic [2:0]   op;
    logic [1:0]   sh;
  } instr_t;

  instr_t m;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Value of register rs as the EX instruction must see it, given producers in flight.
  function automatic logic [W-1:0] see_reg(input logic [4:0] rs, input logic [W-1:0] rf);
    if (rs == 5'd0) return rf;
    if (bus.i_exmem_reg_write && bus.i_exmem_rd == rs) return bus.i_exmem_result;
    if (bus.i_memwb_reg_write && bus.i_memwb_rd == rs) return bus.i_memwb_result;
    return rf;
  endfunction

  function automatic logic m_hazard(input instr_t s);
    return s.valid && s.mr && s.rd != 5'd0 && bus.i_id_valid &&
           (s.rd == bus.i_id_rs1 || s.rd == bus.i_id_rs2);
  endfunction

  function automatic instr_t m_next(input instr_t s);
    instr_t n;
    if (bus.i_flush) return '0;
    if (bus.i_stall) begin
      n    = s;
      n.d1 = see_reg(s.rs1, s.d1);
      n.d2 = see_reg(s.rs2, s.d2);
      return n;
    end
    if (m_hazard(s) || !bus.i_id_valid) return '0;
    n = '{valid: 1'b1, rw: bus.i_id_reg_write, mr: bus.i_id_mem_read, mw: bus.i_id_mem_write,
          a_pc: bus.i_id_src_a_pc, b_imm: bus.i_id_src_b_imm, rs1: bus.i_id_rs1,
          rs2: bus.i_id_rs2, rd: bus.i_id_rd, d1: bus.i_id_rs1_data, d2: bus.i_id_rs2_data,
          pc: bus.i_id_pc, imm: bus.i_id_imm, op: bus.i_id_alu_op, sh: bus.i_id_alu_shift};
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= m_next(m);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("op_a",   64'(bus.o_op_a),   64'(m.a_pc ? m.pc : see_reg(m.rs1, m.d1)));
      check("op_b",   64'(bus.o_op_b),   64'(m.b_imm ? m.imm : see_reg(m.rs2, m.d2)));
      check("store",  64'(bus.o_store_data), 64'(see_reg(m.rs2, m.d2)));
      check("alu_op", 64'(bus.o_alu_op), 64'(m.op));
      check("shift",  64'(bus.o_alu_shift), 64'(m.sh));
      check("ex_pc",  64'(bus.o_ex_pc),  64'(m.pc));
      check("ex_rd",  64'(bus.o_ex_rd),  64'(m.rd));
      check("ctrl",   64'({bus.o_ex_valid, bus.o_ex_reg_write, bus.o_ex_mem_read,
                           bus.o_ex_mem_write}), 64'({m.valid, m.rw, m.mr, m.mw}));
      check("hazard", 64'(bus.o_load_use_hazard), 64'(m_hazard(m)));
    end
  end

  task automatic clear_inputs();
    bus.i_id_valid = 0; bus.i_id_pc = '0; bus.i_id_rs1_data = '0; bus.i_id_rs2_data = '0;
    bus.i_id_rs1 = '0; bus.i_id_rs2 = '0; bus.i_id_rd = '0; bus.i_id_imm = '0;
    bus.i_id_alu_op = '0; bus.i_id_alu_shift = '0; bus.i_id_src_a_pc = 0;
    bus.i_id_src_b_imm = 0; bus.i_id_reg_write = 0; bus.i_id_mem_read = 0;
    bus.i_id_mem_write = 0; bus.i_stall = 0; bus.i_flush = 0;
    bus.i_exmem_rd = '0; bus.i_exmem_reg_write = 0; bus.i_exmem_result = '0;
    bus.i_memwb_rd = '0; bus.i_memwb_reg_write = 0; bus.i_memwb_result = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd_w();
    return W'({$urandom(), $urandom()});
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    clear_inputs();
    #11;
    check("rst_valid",  64'(bus.o_ex_valid), 64'd0);
    check("rst_op_a",   64'(bus.o_op_a), 64'd0);
    check("rst_op_b",   64'(bus.o_op_b), 64'd0);
    check("rst_alu_op", 64'(bus.o_alu_op), 64'd0);
    check("rst_hazard", 64'(bus.o_load_use_hazard), 64'd0);
    #1 rst_n = 1'b1;

    // ADD x1, x5(10), x6(3)
    bus.i_id_valid = 1; bus.i_id_rs1 = 5; bus.i_id_rs1_data = 10;
    bus.i_id_rs2 = 6; bus.i_id_rs2_data = 3; bus.i_id_rd = 1; bus.i_id_reg_write = 1;
    step();
    check("add_op_a",  64'(bus.o_op_a), 64'd10);
    check("add_op_b",  64'(bus.o_op_b), 64'd3);
    check("add_valid", 64'(bus.o_ex_valid), 64'd1);

    // Both producers target rs1=7
    bus.i_id_rs1 = 7; bus.i_id_rs1_data = 'h11;
    bus.i_exmem_rd = 7; bus.i_exmem_reg_write = 1; bus.i_exmem_result = 'h55;
    bus.i_memwb_rd = 7; bus.i_memwb_reg_write = 1; bus.i_memwb_result = 'h99;
    step();
    check("dual_exmem", 64'(bus.o_op_a), 64'h55);
    bus.i_exmem_reg_write = 0;
    #1;
    check("dual_memwb", 64'(bus.o_op_a), 64'h99);
    bus.i_id_rs1 = 0; bus.i_id_rs1_data = 'h22;
    bus.i_exmem_rd = 0; bus.i_exmem_reg_write = 1; bus.i_memwb_rd = 0;
    step();
    check("x0_nofwd", 64'(bus.o_op_a), 64'h22);
    clear_inputs();

    // lw x4 followed by a consumer of x4 in rs2
    bus.i_id_valid = 1; bus.i_id_rd = 4; bus.i_id_mem_read = 1; bus.i_id_reg_write = 1;
    step();
    bus.i_id_mem_read = 0; bus.i_id_rd = 2; bus.i_id_rs1 = 1; bus.i_id_rs2 = 4;
    bus.i_id_rs2_data = 'h44;
    #1;
    check("lu_hazard", 64'(bus.o_load_use_hazard), 64'd1);
    step();
    check("lu_bubble", 64'(bus.o_ex_valid), 64'd0);
    check("lu_clear",  64'(bus.o_load_use_hazard), 64'd0);
    step();
    check("lu_capture", 64'(bus.o_ex_valid), 64'd1);
    check("lu_op_b",    64'(bus.o_op_b), 64'h44);
    clear_inputs();

    // Stall while a MEM/WB producer for rs2=9 passes for one cycle
    bus.i_id_valid = 1; bus.i_id_rs2 = 9; bus.i_id_rs2_data = 'h7;
    step();
    bus.i_id_valid = 0; bus.i_stall = 1;
    bus.i_memwb_rd = 9; bus.i_memwb_reg_write = 1; bus.i_memwb_result = 'h1234;
    step();
    bus.i_memwb_reg_write = 0;
    #1;
    check("stall_op_b1", 64'(bus.o_op_b), 64'h1234);
    step();
    step();
    check("stall_op_b3", 64'(bus.o_op_b), 64'h1234);
    check("stall_valid", 64'(bus.o_ex_valid), 64'd1);
    clear_inputs();

    // Flush beats stall
    bus.i_id_valid = 1; bus.i_id_reg_write = 1; bus.i_id_mem_write = 1;
    step();
    bus.i_id_valid = 0; bus.i_flush = 1; bus.i_stall = 1;
    step();
    check("flush_ctrl", 64'({bus.o_ex_valid, bus.o_ex_reg_write, bus.o_ex_mem_write}), 64'd0);
    clear_inputs();

    // Async reset in the middle of a stall
    bus.i_id_valid = 1; bus.i_id_pc = 'h100; bus.i_id_src_a_pc = 1; bus.i_id_rd = 3;
    bus.i_id_rs2 = 2; bus.i_id_rs2_data = 'hABC; bus.i_id_alu_op = 5; bus.i_id_reg_write = 1;
    step();
    clear_inputs();
    bus.i_stall = 1;
    step();
    #2 rst_n = 1'b0;
    #1;
    check("arst_out", 64'({bus.o_ex_valid, bus.o_ex_reg_write, bus.o_ex_rd, bus.o_alu_op,
                          bus.o_load_use_hazard}), 64'd0);
    check("arst_op_a",  64'(bus.o_op_a), 64'd0);
    check("arst_store", 64'(bus.o_store_data), 64'd0);
    check("arst_pc",    64'(bus.o_ex_pc), 64'd0);
    #1 rst_n = 1'b1;
    bus.i_stall = 0;

    for (int i = 0; i < 2000; i++) begin
      step();
      bus.i_id_valid        = ($urandom_range(0, 3) != 0);
      bus.i_id_pc           = rnd_w();
      bus.i_id_rs1_data     = rnd_w();
      bus.i_id_rs2_data     = rnd_w();
      bus.i_id_rs1          = 5'($urandom_range(0, 7));
      bus.i_id_rs2          = 5'($urandom_range(0, 7));
      bus.i_id_rd           = 5'($urandom_range(0, 7));
      bus.i_id_imm          = rnd_w();
      bus.i_id_alu_op       = 3'($urandom);
      bus.i_id_alu_shift    = 2'($urandom);
      bus.i_id_src_a_pc     = 1'($urandom);
      bus.i_id_src_b_imm    = 1'($urandom);
      bus.i_id_reg_write    = 1'($urandom);
      bus.i_id_mem_read     = ($urandom_range(0, 2) == 0);
      bus.i_id_mem_write    = 1'($urandom);
      bus.i_stall           = ($urandom_range(0, 3) == 0);
      bus.i_flush           = ($urandom_range(0, 15) == 0);
      bus.i_exmem_rd        = 5'($urandom_range(0, 7));
      bus.i_exmem_reg_write = 1'($urandom);
      bus.i_exmem_result    = rnd_w();
      bus.i_memwb_rd        = 5'($urandom_range(0, 7));
      bus.i_memwb_reg_write = 1'($urandom);
      bus.i_memwb_result    = rnd_w();
    end
    step();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register plus EX-stage operand forwarding for the RV pipeline.
- Captures decoded instructions from ID and resolves rs1/rs2 against the EX/MEM and MEM/WB results.
- Selects PC/immediate sources and drives operand A/B, ALU op and shift select straight into the main ALU.
- Detects load-use hazards and inserts bubbles.

Parameters:
- XLEN, 1, width code; data width W = 1<<(XLEN+4), so 1 gives 32 bits and 2 gives 64 bits.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_id_valid  in  1  ID holds a real instruction.
- i_id_pc  in  W  instruction PC.
- i_id_rs1_data, i_id_rs2_data  in  W  register file read data.
- i_id_rs1, i_id_rs2, i_id_rd  in  5  register indices.
- i_id_imm  in  W  sign-extended immediate.
- i_id_alu_op  in  3  ALU control code.
- i_id_alu_shift  in  2  shift type.
- i_id_src_a_pc  in  1  operand A = PC.
- i_id_src_b_imm  in  1  operand B = immediate.
- i_id_reg_write, i_id_mem_read, i_id_mem_write  in  1  control bits.
- i_stall  in  1  hold the EX register (downstream busy).
- i_flush  in  1  kill the EX contents (branch or exception).
- i_exmem_rd  in  5, i_exmem_reg_write  in  1, i_exmem_result  in  W  EX/MEM producer.
- i_memwb_rd  in  5, i_memwb_reg_write  in  1, i_memwb_result  in  W  MEM/WB producer.
- o_op_a, o_op_b  out  W  ALU operands.
- o_alu_op  out  3, o_alu_shift  out  2  to ALU.
- o_store_data  out  W  forwarded rs2 value.
- o_ex_pc  out  W, o_ex_rd  out  5  registered PC and rd.
- o_ex_valid, o_ex_reg_write, o_ex_mem_read, o_ex_mem_write  out  1  registered control.
- o_load_use_hazard  out  1  ID must stall and PC must hold.

Behaviour:
- Reset (async, i_rst_n=0): every register is 0, so every output is 0. The registers include valid, control, rs/rd indices, data, PC, imm, alu_op and shift.
- Register update priority on each clock edge, first match wins:
  - i_flush: load a bubble.
  - i_stall: hold the instruction, but refresh stored rs1/rs2 data (see operand refresh).
  - o_load_use_hazard: load a bubble.
  - Otherwise: capture all i_id_* fields.
- If i_id_valid=0 at capture, the captured entry is a bubble.
- Bubble: valid, reg_write, mem_read, mem_write = 0; rd, rs1, rs2 = 0. Data fields are don't-care; zero them.
- Forwarding is combinational from the registered rs indices:
  - EX/MEM wins when i_exmem_reg_write=1, i_exmem_rd!=0 and i_exmem_rd==ex_rs.
  - Otherwise MEM/WB wins under the same rule.
  - Otherwise the registered rs data is used.
  - x0 is never forwarded.
- Operand refresh: while i_stall=1 and i_flush=0, stored rs1/rs2 data is overwritten each cycle with the forwarded values. A producer retiring during the stall therefore cannot be lost.
- Operand select:
  - o_op_a = src_a_pc ? ex_pc : fwd_rs1.
  - o_op_b = src_b_imm ? ex_imm : fwd_rs2.
  - o_store_data = fwd_rs2, independent of src_b_imm.
- Operand outputs are combinational from registers and forwarding inputs, with no added latency. o_alu_op and o_alu_shift come directly from registers.
- o_load_use_hazard = o_ex_valid & o_ex_mem_read & o_ex_rd!=0 & i_id_valid & (o_ex_rd==i_id_rs1 | o_ex_rd==i_id_rs2). It is combinational and comparison-based: no decode of rs usage, conservative.
- Simultaneous cases:
  - i_flush and i_stall together: flush wins.
  - Hazard and i_stall together: hold wins, because the bubble is only inserted when EX advances.
- Width: all data paths are W bits; no truncation or extension inside the block.
- Reset asserted mid-operation clears state immediately; the first post-reset cycle presents a bubble.

Test Plan:
- Reset → o_ex_valid=0, o_op_a=0, o_op_b=0, o_alu_op=0, o_load_use_hazard=0.
- Capture ADD with rs1=5 (data 10), rs2=6 (data 3), no producers → next cycle o_op_a=10, o_op_b=3, o_ex_valid=1.
- Dual match: EX instr rs1=7; EX/MEM rd=7 result 0x55; MEM/WB rd=7 result 0x99 → o_op_a=0x55. Drop i_exmem_reg_write → o_op_a=0x99. Set rs1=0 with rd=0 matches → registered data is used.
- Load-use: EX holds lw rd=4 (valid, mem_read); ID instr rs2=4 → o_load_use_hazard=1. The next edge loads a bubble (o_ex_valid=0). The following cycle has hazard=0 and the instr captures normally.
- Stall with refresh: i_stall=1 for 3 cycles while MEM/WB rd=9 result 0x1234 shows for 1 cycle only; EX rs2=9, src_b_imm=0 → o_op_b stays 0x1234 after the producer leaves.
- i_flush=1 together with i_stall=1 → next cycle o_ex_valid=0, o_ex_reg_write=0, o_ex_mem_write=0. Async reset pulsed mid-stall → all outputs 0 immediately.
